// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit datapath: opcodes, flag indices, execute FSM states.
// writes_result() honours EXECUTE_UNIT_8_MUL_EN (opcode 14 is a NOP when it is undefined).
package cpu8_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpNot = 4'd5,
        OpShl = 4'd6,
        OpShr = 4'd7,
        OpAdc = 4'd8,
        OpSbc = 4'd9,
        OpCmp = 4'd10,
        OpMov = 4'd11,
        OpInc = 4'd12,
        OpDec = 4'd13,
        OpMul = 4'd14,
        OpNop = 4'd15
    } op_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } exec_state_e;

    function automatic logic writes_result(op_e op);
`ifdef EXECUTE_UNIT_8_MUL_EN
        return !(op inside {OpCmp, OpNop});
`else
        return !(op inside {OpCmp, OpNop, OpMul});
`endif
    endfunction

endpackage

// File: rtl/execute_unit_8_if.sv
// Operation/result handshake and writeback bus of the execute stage.
// master = upstream/consumer side, slave = the execute unit.
interface execute_unit_8_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [SEL_W-1:0]  dest_sel;
    logic              out_valid;
    logic              out_ready;
    logic              wb_enable;
    logic [SEL_W-1:0]  wb_select;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        flags;
    logic              busy;

    modport master (
        output in_valid, op, operand_a, operand_b, dest_sel, out_ready,
        input  in_ready, out_valid, wb_enable, wb_select, wb_data, flags, busy
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, dest_sel, out_ready,
        output in_ready, out_valid, wb_enable, wb_select, wb_data, flags, busy
    );
endinterface

// File: rtl/mul_8x8_iter.sv
// Iterative 8x8 shift-add multiplier: one partial product per cycle, done pulses after 8.
// Only compiled when EXECUTE_UNIT_8_MUL_EN is defined.
`ifdef EXECUTE_UNIT_8_MUL_EN
module mul_8x8_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        done,
    output logic [15:0] product
);
    logic [15:0] mcand_q;
    logic [7:0]  mplier_q;
    logic [15:0] prod_q;
    logic [2:0]  cnt_q;
    logic        run_q;
    logic        done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                mcand_q  <= {8'd0, a};
                mplier_q <= b;
                prod_q   <= '0;
                cnt_q    <= '0;
                run_q    <= 1'b1;
            end else if (run_q) begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= {mcand_q[14:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[7:1]};
                cnt_q    <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign product = prod_q;
endmodule
`endif

// File: rtl/execute_unit_8.sv
// Execute stage: ALU + flags + writeback with valid/ready on both sides.
// EXECUTE_UNIT_8_MUL_EN enables the iterative MUL for opcode 14; otherwise it acts as NOP.
module execute_unit_8
    import cpu8_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SEL_W       = 3,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input logic             clk,
    input logic             rst,
    execute_unit_8_if.slave bus
);
    localparam int unsigned MSB = DATA_W - 1;

    if (DATA_W != 8) begin : g_bad_width
        $error("execute_unit_8 supports DATA_W == 8 only");
    end

    exec_state_e       state_q, state_d;
    logic [DATA_W-1:0] res_q;
    logic [SEL_W-1:0]  sel_q;
    logic              wr_q;
    logic [3:0]        flags_q;

    op_e               op_in;
    logic [DATA_W-1:0] a, b;
    logic              accept, is_mul, in_ready_s, mul_start;
    logic              mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    assign op_in  = op_e'(bus.op);
    assign a      = bus.operand_a;
    assign b      = bus.operand_b;
    assign accept = bus.in_valid & in_ready_s;

`ifdef EXECUTE_UNIT_8_MUL_EN
    assign is_mul = (op_in == OpMul);
    mul_8x8_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    // Single-cycle ALU; subtract paths yield borrow in ext[DATA_W] directly.
    logic [DATA_W:0]   ext;
    logic [DATA_W-1:0] rhs, alu_res;
    logic              alu_c, alu_v, alu_upd;
    logic [3:0]        alu_flags, mul_flags;

    always_comb begin
        ext     = '0;
        rhs     = b;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b1;
        unique case (op_in)
            OpAdd, OpAdc, OpInc: begin
                rhs     = (op_in == OpInc) ? DATA_W'(1) : b;
                ext     = {1'b0, a} + {1'b0, rhs}
                        + {{DATA_W{1'b0}}, (op_in == OpAdc) & flags_q[FLAG_C]};
                alu_res = ext[DATA_W-1:0];
                alu_c   = ext[DATA_W];
                alu_v   = (a[MSB] == rhs[MSB]) & (alu_res[MSB] != a[MSB]);
            end
            OpSub, OpSbc, OpCmp, OpDec: begin
                rhs     = (op_in == OpDec) ? DATA_W'(1) : b;
                ext     = {1'b0, a} - {1'b0, rhs}
                        - {{DATA_W{1'b0}}, (op_in == OpSbc) & flags_q[FLAG_C]};
                alu_res = ext[DATA_W-1:0];
                alu_c   = ext[DATA_W];
                alu_v   = (a[MSB] != rhs[MSB]) & (alu_res[MSB] != a[MSB]);
            end
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpXor: alu_res = a ^ b;
            OpNot: alu_res = ~a;
            OpMov: alu_res = b;
            OpShl: begin
                alu_res = {a[MSB-1:0], 1'b0};
                alu_c   = a[MSB];
            end
            OpShr: begin
                alu_res = {1'b0, a[MSB:1]};
                alu_c   = a[0];
            end
            OpMul, OpNop: alu_upd = 1'b0;
        endcase

        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[MSB];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;

        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_prod[DATA_W-1:0] == '0);
        mul_flags[FLAG_N] = mul_prod[MSB];
        mul_flags[FLAG_C] = |mul_prod[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = is_mul ? StMul : StDone;
            StMul:  if (mul_done) state_d = StDone;
            StDone: begin
                if (bus.out_ready) begin
                    state_d = accept ? (is_mul ? StMul : StDone) : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_s    = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
        mul_start     = accept & is_mul;
        bus.in_ready  = in_ready_s;
        bus.busy      = (state_q != StIdle);
        bus.out_valid = (state_q == StDone);
        bus.wb_enable = (state_q == StDone) & bus.out_ready & wr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q   <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            flags_q <= RESET_FLAGS;
        end else if (accept) begin
            sel_q <= bus.dest_sel;
            wr_q  <= writes_result(op_in);
            if (!is_mul) begin
                res_q <= alu_res;
                if (alu_upd) flags_q <= alu_flags;
            end
        end else if ((state_q == StMul) && mul_done) begin
            res_q   <= mul_prod[DATA_W-1:0];
            flags_q <= mul_flags;
        end
    end

    assign bus.wb_data   = res_q;
    assign bus.wb_select = sel_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_execute_unit_8.sv
// Directed bench for execute_unit_8: vector table plus MUL, backpressure and reset sequences.
module tb_execute_unit_8;
    import cpu8_pkg::*;

    logic clk;
    logic rst;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    execute_unit_8_if bus ();

    execute_unit_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        op_e        op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] data;
        logic [3:0] flg;   // {V,C,N,Z}
        logic       wb;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input op_e op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_sel  = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Carry chain matters: ADC/SBC rows depend on the C left by the row before.
        vecs[0]  = '{OpAdd, 8'h7F, 8'h01, 3'd1, 8'h80, 4'b1010, 1'b1};
        vecs[1]  = '{OpSub, 8'h10, 8'h20, 3'd2, 8'hF0, 4'b0110, 1'b1};
        vecs[2]  = '{OpSbc, 8'h05, 8'h00, 3'd3, 8'h04, 4'b0000, 1'b1};
        vecs[3]  = '{OpCmp, 8'h33, 8'h33, 3'd4, 8'h00, 4'b0001, 1'b0};
        vecs[4]  = '{OpAnd, 8'hF0, 8'h3C, 3'd5, 8'h30, 4'b0000, 1'b1};
        vecs[5]  = '{OpOr,  8'h0F, 8'hF0, 3'd6, 8'hFF, 4'b0010, 1'b1};
        vecs[6]  = '{OpXor, 8'hAA, 8'hAA, 3'd7, 8'h00, 4'b0001, 1'b1};
        vecs[7]  = '{OpNot, 8'h0F, 8'h00, 3'd0, 8'hF0, 4'b0010, 1'b1};
        vecs[8]  = '{OpShl, 8'h81, 8'h00, 3'd1, 8'h02, 4'b0100, 1'b1};
        vecs[9]  = '{OpShr, 8'h01, 8'h00, 3'd2, 8'h00, 4'b0101, 1'b1};
        vecs[10] = '{OpAdc, 8'hFF, 8'h00, 3'd3, 8'h00, 4'b0101, 1'b1};
        vecs[11] = '{OpAdc, 8'h01, 8'h01, 3'd4, 8'h03, 4'b0000, 1'b1};
        vecs[12] = '{OpMov, 8'h11, 8'h80, 3'd5, 8'h80, 4'b0010, 1'b1};
        vecs[13] = '{OpInc, 8'h7F, 8'h00, 3'd6, 8'h80, 4'b1010, 1'b1};
        vecs[14] = '{OpDec, 8'h00, 8'h00, 3'd7, 8'hFF, 4'b0110, 1'b1};
        vecs[15] = '{OpInc, 8'hFF, 8'h00, 3'd0, 8'h00, 4'b0101, 1'b1};
        vecs[16] = '{OpDec, 8'h80, 8'h00, 3'd1, 8'h7F, 4'b1000, 1'b1};
        vecs[17] = '{OpNop, 8'h12, 8'h34, 3'd2, 8'h00, 4'b1000, 1'b0};
        vecs[18] = '{OpAdd, 8'hFF, 8'h01, 3'd3, 8'h00, 4'b0101, 1'b1};
        vecs[19] = '{OpSbc, 8'h00, 8'h00, 3'd4, 8'hFF, 4'b0110, 1'b1};

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_sel  = '0;
        bus.out_ready = 1'b1;
        tick();
        check("rst out_valid", {31'd0, bus.out_valid}, 0);
        check("rst busy", {31'd0, bus.busy}, 0);
        check("rst flags", {28'd0, bus.flags}, 0);
        check("rst wb_data", {24'd0, bus.wb_data}, 0);
        check("rst wb_select", {29'd0, bus.wb_select}, 0);
        tick();
        rst = 1'b1;
        tick();
        check("idle in_ready", {31'd0, bus.in_ready}, 1);

        // Back-to-back, one op per clock with out_ready high.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sel);
            check($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, 1);
            tick();
            check($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, 1);
            check($sformatf("v%0d flags", i), {28'd0, bus.flags}, {28'd0, vecs[i].flg});
            check($sformatf("v%0d wb_enable", i), {31'd0, bus.wb_enable}, {31'd0, vecs[i].wb});
            if (vecs[i].op != OpNop)
                check($sformatf("v%0d data", i), {24'd0, bus.wb_data}, {24'd0, vecs[i].data});
            if (vecs[i].wb)
                check($sformatf("v%0d select", i), {29'd0, bus.wb_select}, {29'd0, vecs[i].sel});
        end
        bus.in_valid = 1'b0;
        tick();
        check("post-table busy", {31'd0, bus.busy}, 0);

        // MUL 0x12 * 0x10 = 0x120; flags entering are 0110.
        drive(OpMul, 8'h12, 8'h10, 3'd5);
        check("mul in_ready", {31'd0, bus.in_ready}, 1);
        tick();
        bus.in_valid = 1'b0;
`ifdef EXECUTE_UNIT_8_MUL_EN
        for (int k = 0; k < 9; k++) begin
            check($sformatf("mul c%0d busy", k), {31'd0, bus.busy}, 1);
            check($sformatf("mul c%0d in_ready", k), {31'd0, bus.in_ready}, 0);
            check($sformatf("mul c%0d out_valid", k), {31'd0, bus.out_valid}, 0);
            tick();
        end
        check("mul out_valid", {31'd0, bus.out_valid}, 1);
        check("mul data", {24'd0, bus.wb_data}, 32'h20);
        check("mul flags", {28'd0, bus.flags}, 32'b0100);
        check("mul wb_enable", {31'd0, bus.wb_enable}, 1);
        check("mul select", {29'd0, bus.wb_select}, 5);
`else
        check("mulnop out_valid", {31'd0, bus.out_valid}, 1);
        check("mulnop wb_enable", {31'd0, bus.wb_enable}, 0);
        check("mulnop flags", {28'd0, bus.flags}, 32'b0110);
`endif
        tick();

        // Backpressure: ADD held for 5 cycles while a SUB waits upstream.
        bus.out_ready = 1'b0;
        drive(OpAdd, 8'h7F, 8'h01, 3'd6);
        tick();
        drive(OpSub, 8'h10, 8'h20, 3'd7);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp c%0d out_valid", k), {31'd0, bus.out_valid}, 1);
            check($sformatf("bp c%0d data", k), {24'd0, bus.wb_data}, 32'h80);
            check($sformatf("bp c%0d flags", k), {28'd0, bus.flags}, 32'b1010);
            check($sformatf("bp c%0d in_ready", k), {31'd0, bus.in_ready}, 0);
            check($sformatf("bp c%0d wb_enable", k), {31'd0, bus.wb_enable}, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release wb_enable", {31'd0, bus.wb_enable}, 1);
        check("bp release in_ready", {31'd0, bus.in_ready}, 1);
        check("bp release select", {29'd0, bus.wb_select}, 6);
        tick();
        bus.in_valid = 1'b0;
        check("bp next out_valid", {31'd0, bus.out_valid}, 1);
        check("bp next data", {24'd0, bus.wb_data}, 32'hF0);
        check("bp next flags", {28'd0, bus.flags}, 32'b0110);
        check("bp next select", {29'd0, bus.wb_select}, 7);
        tick();

        // Reset mid-operation discards the in-flight result.
`ifdef EXECUTE_UNIT_8_MUL_EN
        drive(OpMul, 8'h12, 8'h10, 3'd2);
`else
        bus.out_ready = 1'b0;
        drive(OpAdd, 8'h12, 8'h10, 3'd2);
`endif
        tick();
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst out_valid", {31'd0, bus.out_valid}, 0);
        check("arst busy", {31'd0, bus.busy}, 0);
        check("arst flags", {28'd0, bus.flags}, 0);
        check("arst wb_data", {24'd0, bus.wb_data}, 0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("post-rst c%0d wb_enable", k), {31'd0, bus.wb_enable}, 0);
            check($sformatf("post-rst c%0d out_valid", k), {31'd0, bus.out_valid}, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
